// File: rtl/vscpu_boot_loader_if.sv
// Byte-stream, CPU-side RAM port and RAM port bundle for the VSCPU boot loader.
// slave  : the loader (consumes bytes and CPU requests, drives the RAM port)
// master : the environment (byte source, CPU, RAM)
interface vscpu_boot_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cpu_wrEn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;

  modport slave (
    input  in_data, in_valid, cpu_wrEn, cpu_addr, cpu_data,
    output in_ready, ram_we, ram_addr, ram_din
  );

  modport master (
    output in_data, in_valid, cpu_wrEn, cpu_addr, cpu_data,
    input  in_ready, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/vscpu_boot_loader.sv
// VSCPU boot loader: assembles a big-endian byte stream (16-bit word count,
// then 4 bytes per word) into 32-bit RAM writes from address 0 while the CPU
// is held in reset, then hands the RAM port to the CPU and releases it.
module vscpu_boot_loader #(
  parameter int ADDR_W   = 14,
  parameter int HOLD_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic cpu_rst,
  output logic done,
  output logic err,
  vscpu_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, HOLD, RUN, ERR} state_t;

  localparam int          AW1       = ADDR_W + 1;
  localparam int unsigned CAP       = 32'd1 << ADDR_W;
  localparam int          HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_t            state, state_nx;
  logic [7:0]        len_hi;
  logic [15:0]       n_len;
  logic [1:0]        byte_idx;
  logic [AW1-1:0]    word_addr;   // one extra bit so N == capacity never wraps
  logic [23:0]       word_sr;     // first three bytes of the word being built
  logic [HW-1:0]     hold_cnt;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [31:0]       ram_din_r;

  logic        in_rdy, xfer, last_word, cpu_run;
  logic [15:0] len_nx;

  assign in_rdy    = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign xfer      = bus.in_valid && in_rdy;
  assign len_nx    = {len_hi, bus.in_data};
  assign last_word = (32'(word_addr) == (32'(n_len) - 32'd1));
  // CPU owns the RAM port only in RUN and not in the cycle reload is seen
  assign cpu_run   = (state == RUN) && !reload;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LEN_HI;
    else      state <= state_nx;
  end

  // Next-state and output decode
  always_comb begin
    state_nx     = state;
    bus.in_ready = in_rdy;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    err          = (state == ERR);
    bus.ram_we   = ram_we_r;
    bus.ram_addr = ram_addr_r;
    bus.ram_din  = ram_din_r;
    if (cpu_run) begin
      cpu_rst      = 1'b0;
      done         = 1'b1;
      bus.ram_we   = bus.cpu_wrEn;
      bus.ram_addr = bus.cpu_addr;
      bus.ram_din  = bus.cpu_data;
    end
    case (state)
      LEN_HI: if (xfer) state_nx = LEN_LO;
      LEN_LO: if (xfer) begin
        if (len_nx == 16'd0)         state_nx = HOLD;
        else if (32'(len_nx) > CAP)  state_nx = ERR;
        else                         state_nx = DATA;
      end
      DATA:   if (xfer && byte_idx == 2'd3) state_nx = WRITE;
      WRITE:  state_nx = last_word ? HOLD : DATA;
      HOLD:   if (hold_cnt == HOLD_LAST) state_nx = RUN;
      RUN:    if (reload) state_nx = LEN_HI;
      ERR:    state_nx = ERR;
      default: state_nx = LEN_HI;
    endcase
  end

  // Datapath: length capture, word assembly, registered RAM write, hold timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi     <= '0;
      n_len      <= '0;
      byte_idx   <= '0;
      word_addr  <= '0;
      word_sr    <= '0;
      hold_cnt   <= '0;
      ram_we_r   <= 1'b0;
      ram_addr_r <= '0;
      ram_din_r  <= '0;
    end else begin
      ram_we_r <= 1'b0;
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      case (state)
        LEN_HI: if (xfer) len_hi <= bus.in_data;
        LEN_LO: if (xfer) begin
          n_len     <= len_nx;
          byte_idx  <= '0;
          word_addr <= '0;
        end
        DATA: if (xfer) begin
          word_sr  <= {word_sr[15:0], bus.in_data};
          byte_idx <= byte_idx + 2'd1;
          // 4th byte: present the write in the very next (WRITE) cycle
          if (byte_idx == 2'd3) begin
            ram_we_r   <= 1'b1;
            ram_addr_r <= word_addr[ADDR_W-1:0];
            ram_din_r  <= {word_sr, bus.in_data};
          end
        end
        WRITE: word_addr <= word_addr + AW1'(1);
        RUN: if (reload) begin
          word_addr <= '0;
          byte_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vscpu_boot_loader.sv
// Scoreboard bench for vscpu_boot_loader: expected RAM writes are queued as
// bytes are driven and popped by a monitor whenever the loader writes.
module tb_vscpu_boot_loader;
  localparam int ADDR_W   = 14;
  localparam int HOLD_CYC = 2;

  logic clk, rst, reload, cpu_rst, done, err;
  vscpu_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  vscpu_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .cpu_rst(cpu_rst), .done(done), .err(err), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [ADDR_W+31:0] sb[$];
  logic [31:0]        prog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Loader-side write monitor (CPU-owned writes happen only with done=1)
  always @(negedge clk) begin
    if (rst && bus.ram_we && !done) begin
      wr_cnt++;
      if (sb.size() == 0) chk("unexpected_write", 64'(bus.ram_addr), 64'hFFFF);
      else begin
        logic [ADDR_W+31:0] e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.ram_addr), 64'(e[ADDR_W+31:32]));
        chk("wr_data", 64'(bus.ram_din),  64'(e[31:0]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int t;
    t = 0;
    if (rnd) begin
      while ($urandom_range(0, 2) != 0 && t < 8) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        t++;
      end
    end
    t = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic stream(input logic [15:0] n, input bit rnd);
    logic [31:0] w;
    send_byte(n[15:8], rnd);
    send_byte(n[7:0], rnd);
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      sb.push_back({ADDR_W'(i), w});
      send_byte(w[31:24], rnd);
      send_byte(w[23:16], rnd);
      send_byte(w[15:8], rnd);
      send_byte(w[7:0], rnd);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int cnt;
    cnt = 0;
    while (!done && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, 64'(cnt), 64'(exp_lat));
    chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    #1;
    chk("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_ram_we", 64'(bus.ram_we), 64'd0);
    @(negedge clk);
    reload = 1'b0;
    bus.cpu_wrEn = 1'b0;
    chk("reload_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b0; reload = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0;
    bus.cpu_wrEn = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    #3;
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("rst_ram_din", 64'(bus.ram_din), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1: two-word load, latency from final write to CPU release
    prog = '{32'h20004001, 32'h00000005};
    w0 = wr_cnt;
    stream(16'd2, 1'b0);
    chk("t1_write_cycle_cpu_rst", 64'(cpu_rst), 64'd1);
    wait_done("t1_lat", HOLD_CYC + 1);
    chk("t1_wr_cnt", 64'(wr_cnt - w0), 64'd2);
    chk("t1_in_ready_run", 64'(bus.in_ready), 64'd0);

    // 2: same program with random in_valid gaps
    do_reload();
    w0 = wr_cnt;
    stream(16'd2, 1'b1);
    wait_done("t2_lat", HOLD_CYC + 1);
    chk("t2_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    // 3: empty program
    do_reload();
    prog = {};
    w0 = wr_cnt;
    stream(16'd0, 1'b0);
    wait_done("t3_lat", HOLD_CYC);
    chk("t3_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // 5: CPU pass-through in RUN, then reload ignores CPU writes
    bus.cpu_wrEn = 1'b1; bus.cpu_addr = 14'h3FFF; bus.cpu_data = 32'hDEADBEEF;
    #1;
    chk("t5_pass_we", 64'(bus.ram_we), 64'd1);
    chk("t5_pass_addr", 64'(bus.ram_addr), 64'h3FFF);
    chk("t5_pass_din", 64'(bus.ram_din), 64'hDEADBEEF);
    @(negedge clk);
    do_reload();
    prog = '{32'h11223344};
    w0 = wr_cnt;
    stream(16'd1, 1'b0);
    wait_done("t5_lat", HOLD_CYC + 1);
    chk("t5_wr_cnt", 64'(wr_cnt - w0), 64'd1);

    // 4: oversize length -> sticky error
    do_reload();
    prog = {};
    w0 = wr_cnt;
    stream(16'h4001, 1'b0);
    repeat (3) @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t4_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_wr_cnt", 64'(wr_cnt - w0), 64'd0);

    // 6: reset mid-load, then a fresh load from address 0
    rst = 1'b0;
    #2;
    chk("t6_err_clear", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    prog = '{32'hCAFE0001};
    w0 = wr_cnt;
    stream(16'd2, 1'b0);
    send_byte(8'h77, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("t6_ram_we", 64'(bus.ram_we), 64'd0);
    chk("t6_ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("t6_ram_din", 64'(bus.ram_din), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_partial_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    prog = '{32'hA5A50001, 32'h0BADF00D};
    w0 = wr_cnt;
    stream(16'd2, 1'b1);
    wait_done("t6_lat", HOLD_CYC + 1);
    chk("t6_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
